// File: rtl/hello_chk_arbiter.sv
// Round-robin, frame-locked arbiter sharing one "hello" checker between N byte sources.
// One owner per frame; the checker is cleared before every frame and matches are attributed to the owner.
module hello_chk_arbiter #(
    parameter int unsigned N_SRC     = 4,
    parameter int unsigned SRC_W     = 2,
    parameter int unsigned TIMEOUT   = 16,
    parameter int unsigned DRAIN_CYC = 3
) (
    input  logic                 sys_clk,
    input  logic                 reset,
    input  logic [8*N_SRC-1:0]   src_data,
    input  logic [N_SRC-1:0]     src_valid,
    input  logic [N_SRC-1:0]     src_last,
    output logic [N_SRC-1:0]     src_ready,
    output logic [7:0]           chk_data,
    output logic                 chk_valid,
    output logic                 chk_reset_n,
    input  logic                 check_ok,
    output logic                 match_valid,
    output logic [SRC_W-1:0]     match_src,
    output logic [SRC_W-1:0]     grant_id,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int unsigned IDLE_W  = $clog2(TIMEOUT + 1);
    localparam int unsigned DRAIN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    typedef enum logic [1:0] {IDLE, CLEAR, GRANT, DRAIN} state_t;

    state_t             state, state_d;
    logic [SRC_W-1:0]   last_owner, last_d, grant_d, pick;
    logic [IDLE_W-1:0]  idle_cnt, idle_d, idle_inc;
    logic [DRAIN_W-1:0] drain_cnt, drain_d;
    logic               check_ok_q, tmo_d, match_d, xfer;
    logic [7:0]         sel_data;
    logic               sel_valid, sel_last;
    int unsigned        d, best_d;

    // Mux the current owner's byte stream
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        src_ready = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (grant_id == SRC_W'(i)) begin
                sel_data     = src_data[8*i +: 8];
                sel_valid    = src_valid[i];
                sel_last     = src_last[i];
                src_ready[i] = (state == GRANT);
            end
        end
    end

    assign xfer     = (state == GRANT) && sel_valid;
    assign idle_inc = idle_cnt + IDLE_W'(1);
    assign match_d  = check_ok && !check_ok_q && ((state == GRANT) || (state == DRAIN));

    // Round-robin pick: nearest valid source after last_owner
    always_comb begin
        pick   = '0;
        best_d = N_SRC;
        d      = 0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            d = (i + 2 * N_SRC - 32'(last_owner) - 1) % N_SRC;
            if (src_valid[i] && (d < best_d)) begin
                best_d = d;
                pick   = SRC_W'(i);
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        grant_d = grant_id;
        last_d  = last_owner;
        idle_d  = idle_cnt;
        drain_d = drain_cnt;
        tmo_d   = 1'b0;
        case (state)
            IDLE: begin
                if (|src_valid) begin
                    grant_d = pick;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                idle_d  = '0;
                state_d = GRANT;
            end
            GRANT: begin
                if (xfer) begin
                    idle_d = '0;
                    if (sel_last) begin
                        state_d = DRAIN;
                        last_d  = grant_id;
                        drain_d = '0;
                    end
                end else if (idle_inc == IDLE_W'(TIMEOUT)) begin
                    tmo_d   = 1'b1;
                    state_d = DRAIN;
                    last_d  = grant_id;
                    drain_d = '0;
                end else begin
                    idle_d = idle_inc;
                end
            end
            DRAIN: begin
                if (drain_cnt == DRAIN_W'(DRAIN_CYC - 1)) begin
                    state_d = IDLE;
                end else begin
                    drain_d = drain_cnt + DRAIN_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state       <= IDLE;
            grant_id    <= '0;
            last_owner  <= SRC_W'(N_SRC - 1);
            idle_cnt    <= '0;
            drain_cnt   <= '0;
            check_ok_q  <= 1'b0;
            chk_data    <= '0;
            chk_valid   <= 1'b0;
            chk_reset_n <= 1'b0;
            match_valid <= 1'b0;
            match_src   <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_d;
            grant_id    <= grant_d;
            last_owner  <= last_d;
            idle_cnt    <= idle_d;
            drain_cnt   <= drain_d;
            check_ok_q  <= check_ok;
            chk_valid   <= xfer;
            if (xfer) begin
                chk_data <= sel_data;
            end
            chk_reset_n <= (state_d != CLEAR);
            match_valid <= match_d;
            if (match_d) begin
                match_src <= grant_id;
            end
            busy        <= (state_d != IDLE);
            timeout_err <= tmo_d;
        end
    end

endmodule

// File: tb/tb_hello_chk_arbiter.sv
// Bench for hello_chk_arbiter: directed frames plus random traffic against a frame-level reference model,
// with a behavioural "hello" checker attached to the chk_* interface.
module tb_hello_chk_arbiter;

    localparam int unsigned N_SRC     = 4;
    localparam int unsigned SRC_W     = 2;
    localparam int unsigned TIMEOUT   = 16;
    localparam int unsigned DRAIN_CYC = 3;

    logic               sys_clk = 1'b0;
    logic               reset   = 1'b1;
    logic [8*N_SRC-1:0] src_data = '0;
    logic [N_SRC-1:0]   src_valid = '0;
    logic [N_SRC-1:0]   src_last = '0;
    logic [N_SRC-1:0]   src_ready;
    logic [7:0]         chk_data;
    logic               chk_valid, chk_reset_n;
    logic               check_ok = 1'b0;
    logic               match_valid, busy, timeout_err;
    logic [SRC_W-1:0]   match_src, grant_id;

    hello_chk_arbiter #(.N_SRC(N_SRC), .SRC_W(SRC_W), .TIMEOUT(TIMEOUT), .DRAIN_CYC(DRAIN_CYC)) dut (
        .sys_clk(sys_clk), .reset(reset), .src_data(src_data), .src_valid(src_valid),
        .src_last(src_last), .src_ready(src_ready), .chk_data(chk_data), .chk_valid(chk_valid),
        .chk_reset_n(chk_reset_n), .check_ok(check_ok), .match_valid(match_valid),
        .match_src(match_src), .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Sources: per-source byte queues, post-transfer stall, optional random gaps
    logic [7:0] q_data [N_SRC][$];
    bit         q_last [N_SRC][$];
    int         stall      [N_SRC];
    int         post_stall [N_SRC];
    bit         gap_mode = 1'b0;

    // Behavioural checker: last five accepted bytes
    logic [39:0] win = '0;
    bit          ok_r = 1'b0;

    // Reference model: frame owner, clear/drain phases, idle count
    int  m_owner, m_last, m_idle, m_drain;
    bit  m_clear, m_granted, m_ok_prev;
    int  e_chk_data, e_msrc, e_grant;
    bit  e_chk_valid, e_rstn, e_mv, e_busy, e_tmo;

    int cyc = 0, obs_match = 0, exp_match = 0, obs_tmo = 0, obs_chk = 0;
    int last_chk_cyc = 0, fall_cyc = 0;
    bit busy_prev = 1'b0;
    int grant_log[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_clear = 0; m_granted = 0; m_drain = 0; m_idle = 0; m_owner = 0;
        m_last = N_SRC - 1; m_ok_prev = 0;
        e_chk_data = 0; e_chk_valid = 0; e_rstn = 0; e_mv = 0; e_msrc = 0;
        e_grant = 0; e_busy = 0; e_tmo = 0;
    endtask

    task automatic model_next();
        bit xfer, rise, found;
        int o, cand;
        if (reset) begin
            model_reset();
            return;
        end
        o    = m_owner;
        xfer = m_granted && src_valid[o];
        rise = check_ok && !m_ok_prev;
        m_ok_prev = check_ok;
        e_mv = rise && (m_granted || m_drain > 0);
        if (e_mv) e_msrc = o;
        e_chk_valid = xfer;
        if (xfer) e_chk_data = int'(src_data[8*o +: 8]);
        e_tmo = 0;
        if (m_clear) begin
            m_clear = 0; m_granted = 1; m_idle = 0;
        end else if (m_granted) begin
            if (xfer) m_idle = 0;
            else      m_idle = m_idle + 1;
            if ((xfer && src_last[o]) || (!xfer && m_idle == int'(TIMEOUT))) begin
                e_tmo     = !xfer;
                m_granted = 0;
                m_drain   = DRAIN_CYC;
                m_last    = o;
            end
        end else if (m_drain > 0) begin
            m_drain = m_drain - 1;
        end else begin
            found = 0;
            for (int k = 1; k <= int'(N_SRC); k++) begin
                cand = (m_last + k) % N_SRC;
                if (!found && src_valid[cand]) begin
                    found = 1; m_owner = cand; e_grant = cand; m_clear = 1;
                end
            end
        end
        e_rstn = !m_clear;
        e_busy = m_clear || m_granted || (m_drain > 0);
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < int'(N_SRC); i++) begin
            src_valid[i] = 1'b0;
            src_last[i]  = 1'b0;
            src_data[8*i +: 8] = 8'h00;
            if (stall[i] > 0) begin
                stall[i] = stall[i] - 1;
            end else if (q_data[i].size() > 0 && (!gap_mode || $urandom_range(0, 3) != 0)) begin
                src_valid[i] = 1'b1;
                src_data[8*i +: 8] = q_data[i][0];
                src_last[i]  = q_last[i][0];
            end
        end
    endtask

    // One clock: compare at negedge, advance model, then drive after posedge
    task automatic step();
        logic [N_SRC-1:0] e_ready;
        logic [7:0] cap_data;
        logic cap_valid, cap_rstn;
        @(negedge sys_clk);
        e_ready = '0;
        if (m_granted) e_ready[m_owner] = 1'b1;
        check_eq("src_ready",   32'(src_ready),   32'(e_ready));
        check_eq("chk_valid",   32'(chk_valid),   32'(e_chk_valid));
        check_eq("chk_data",    32'(chk_data),    32'(e_chk_data));
        check_eq("chk_reset_n", 32'(chk_reset_n), 32'(e_rstn));
        check_eq("match_valid", 32'(match_valid), 32'(e_mv));
        check_eq("match_src",   32'(match_src),   32'(e_msrc));
        check_eq("grant_id",    32'(grant_id),    32'(e_grant));
        check_eq("busy",        32'(busy),        32'(e_busy));
        check_eq("timeout_err", 32'(timeout_err), 32'(e_tmo));
        if (match_valid) obs_match++;
        if (e_mv) exp_match++;
        if (timeout_err) obs_tmo++;
        if (chk_valid) begin obs_chk++; last_chk_cyc = cyc; end
        if (busy_prev && !busy) fall_cyc = cyc;
        if (!chk_reset_n && busy) grant_log.push_back(int'(grant_id));
        busy_prev = busy;
        cap_data = chk_data; cap_valid = chk_valid; cap_rstn = chk_reset_n;
        model_next();
        if (!reset) begin
            for (int i = 0; i < int'(N_SRC); i++) begin
                if (src_valid[i] && e_ready[i]) begin
                    void'(q_data[i].pop_front());
                    void'(q_last[i].pop_front());
                    stall[i] = post_stall[i];
                end
            end
        end
        @(posedge sys_clk);
        #1;
        if (!cap_rstn) begin
            win = '0; ok_r = 1'b0;
        end else if (cap_valid) begin
            win  = {win[31:0], cap_data};
            ok_r = (win == "hello");
        end
        check_ok = ok_r;
        drive_inputs();
        cyc++;
    endtask

    task automatic push_str(input int s, input string str, input bit with_last);
        for (int k = 0; k < str.len(); k++) begin
            q_data[s].push_back(str[k]);
            q_last[s].push_back(with_last && (k == str.len() - 1));
        end
    endtask

    function automatic bit all_idle();
        bit empty = 1'b1;
        for (int i = 0; i < int'(N_SRC); i++) if (q_data[i].size() != 0) empty = 1'b0;
        return empty && !m_clear && !m_granted && (m_drain == 0);
    endfunction

    task automatic run_idle(input string tag, input int max_cyc);
        int n = 0;
        step();
        while (!all_idle() && n < max_cyc) begin step(); n++; end
        check_eq(tag, 32'(all_idle()), 32'd1);
        repeat (2) step();
    endtask

    int m0, t0, c0, n;

    initial begin
        model_reset();
        for (int i = 0; i < int'(N_SRC); i++) begin stall[i] = 0; post_stall[i] = 0; end

        // src1 and src2 valid from reset: src1 wins, then src2
        push_str(1, "ab", 1);
        push_str(2, "cd", 1);
        repeat (3) step();
        reset = 1'b0;
        run_idle("t2_done", 100);
        check_eq("t2_grants", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() == 2) begin
            check_eq("t2_first",  32'(grant_log[0]), 32'd1);
            check_eq("t2_second", 32'(grant_log[1]), 32'd2);
        end

        // "hello" back-to-back from src0
        m0 = obs_match;
        push_str(0, "hello", 1);
        run_idle("t1_done", 100);
        check_eq("t1_matches", 32'(obs_match - m0), 32'd1);
        check_eq("t1_busy_fall", 32'(fall_cyc - last_chk_cyc), 32'(DRAIN_CYC));

        // "hel" then "lo" from another source: no match across frames
        m0 = obs_match;
        push_str(0, "hel", 1);
        repeat (3) step();
        push_str(1, "lo", 1);
        run_idle("t3_done", 100);
        check_eq("t3_matches", 32'(obs_match - m0), 32'd0);

        // src3 stalls mid-frame: forced release
        m0 = obs_match; t0 = obs_tmo;
        push_str(3, "he", 0);
        run_idle("t4_done", 100);
        check_eq("t4_timeouts", 32'(obs_tmo - t0), 32'd1);
        check_eq("t4_matches", 32'(obs_match - m0), 32'd0);

        // reset after "hell", then "o": frame is lost
        m0 = obs_match;
        push_str(0, "hell", 0);
        n = 0;
        while (q_data[0].size() > 0 && n < 50) begin step(); n++; end
        step();
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        check_eq("t5_busy_rst", 32'(busy), 32'd0);
        push_str(0, "o", 1);
        run_idle("t5_done", 100);
        check_eq("t5_matches", 32'(obs_match - m0), 32'd0);

        // bytes arriving on the last idle cycle before timeout keep the grant
        t0 = obs_tmo; c0 = obs_chk;
        post_stall[0] = TIMEOUT - 1;
        push_str(0, "abc", 1);
        run_idle("t6_done", 200);
        post_stall[0] = 0;
        check_eq("t6_timeouts", 32'(obs_tmo - t0), 32'd0);
        check_eq("t6_bytes", 32'(obs_chk - c0), 32'd3);

        // random traffic
        gap_mode = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < int'(N_SRC); i++) begin
                post_stall[i] = ($urandom_range(0, 15) == 0) ? int'($urandom_range(12, 18)) : 0;
                if (q_data[i].size() < 8 && $urandom_range(0, 19) == 0) begin
                    if ($urandom_range(0, 2) == 0) push_str(i, "hello", 1);
                    else begin
                        n = $urandom_range(1, 7);
                        for (int k = 0; k < n; k++) begin
                            case ($urandom_range(0, 3))
                                0: q_data[i].push_back("h");
                                1: q_data[i].push_back("e");
                                2: q_data[i].push_back("l");
                                default: q_data[i].push_back("o");
                            endcase
                            q_last[i].push_back((k == n - 1) && ($urandom_range(0, 9) != 0));
                        end
                    end
                end
            end
            reset = ($urandom_range(0, 699) == 0);
            step();
        end
        reset = 1'b0;
        for (int i = 0; i < int'(N_SRC); i++) post_stall[i] = 0;
        gap_mode = 1'b0;
        run_idle("rand_done", 2000);
        check_eq("rand_matches", 32'(obs_match), 32'(exp_match));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
